// File: rtl/harness_pkg.sv
// Shared types and constants for the CPU bring-up run controller.
// Multi-core harnesses reuse these, so this package holds no logic.
package harness_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RUN,
        DONE_PASS,
        DONE_FAIL,
        DONE_TIMEOUT
    } state_e;

    typedef enum logic [1:0] {
        TH_IGNORE,
        TH_PASS,
        TH_FAIL
    } tohost_kind_e;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR  = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_1004;
    localparam logic [31:0] PASS_VALUE           = 32'd1;

    function automatic logic is_done(input state_e s);
        return s inside {DONE_PASS, DONE_FAIL, DONE_TIMEOUT};
    endfunction

endpackage

// File: rtl/harness_store_decode.sv
// Combinational snoop of one core store: console address match and tohost
// classification. An even tohost value is not a verdict and decodes as ignore.
module harness_store_decode
    import harness_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(DEFAULT_TOHOST_ADDR),
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR = ADDR_W'(DEFAULT_CONSOLE_ADDR)
) (
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              console_hit,
    output tohost_kind_e      tohost_kind
);

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        tohost_kind = TH_IGNORE;
        console_hit = we && (addr == CONSOLE_ADDR);
        if (we && (addr == TOHOST_ADDR)) begin
            if (wdata == DATA_W'(PASS_VALUE)) begin
                tohost_kind = TH_PASS;
            end else if (wdata[0]) begin
                tohost_kind = TH_FAIL;
            end
        end
    end

endmodule

// File: rtl/test_harness_ctrl.sv
// Run controller for CPU bring-up: stretched core reset, RUN watchdog,
// tohost pass/fail capture and a byte console, restartable from DONE.
module test_harness_ctrl
    import harness_pkg::*;
#(
    parameter int unsigned       RST_CYCLES     = 3,
    parameter int unsigned       TIMEOUT_CYCLES = 25,
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       CNT_W          = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(DEFAULT_TOHOST_ADDR),
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = ADDR_W'(DEFAULT_CONSOLE_ADDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic              core_rst_n,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-2:0] fail_code,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              char_valid,
    output logic [7:0]        char_data
);

    localparam int unsigned       HOLD_W    = $clog2(RST_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic              WD_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state;
    state_e            next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              console_hit;
    tohost_kind_e      tohost_kind;
    logic              in_done;
    logic              wd_expire;

    harness_store_decode #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TOHOST_ADDR (TOHOST_ADDR),
        .CONSOLE_ADDR(CONSOLE_ADDR)
    ) u_decode (
        .we         (dmem_we),
        .addr       (dmem_addr),
        .wdata      (dmem_wdata),
        .console_hit(console_hit),
        .tohost_kind(tohost_kind)
    );

    assign in_done   = is_done(state);
    assign wd_expire = WD_EN && (cycle_cnt == WD_LAST);

    // A decisive tohost store is checked before the watchdog so it wins a tie.
    always_comb begin
        next_state = state;
        unique case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) next_state = RUN;
            end
            RUN: begin
                if (tohost_kind == TH_PASS)      next_state = DONE_PASS;
                else if (tohost_kind == TH_FAIL) next_state = DONE_FAIL;
                else if (wd_expire)              next_state = DONE_TIMEOUT;
            end
            DONE_PASS, DONE_FAIL, DONE_TIMEOUT: begin
                if (restart) next_state = HOLD;
            end
            default: next_state = HOLD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            core_rst_n <= 1'b0;
        end else begin
            state      <= next_state;
            hold_cnt   <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
            core_rst_n <= (next_state == RUN);
        end
    end

    // The counter also advances on the edge that leaves RUN, so a verdict
    // store seen at count N freezes the count at N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            fail_code <= '0;
        end else if (state == RUN) begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
            if (tohost_kind == TH_FAIL) fail_code <= dmem_wdata[DATA_W-1:1];
        end else if (in_done && restart) begin
            cycle_cnt <= '0;
            fail_code <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_valid <= 1'b0;
            char_data  <= '0;
        end else begin
            char_valid <= (state == RUN) && console_hit;
            if ((state == RUN) && console_hit) char_data <= dmem_wdata[7:0];
        end
    end

    assign running = (state == RUN);
    assign done    = in_done;
    assign pass    = (state == DONE_PASS);
    assign fail    = (state == DONE_FAIL);
    assign timeout = (state == DONE_TIMEOUT);

endmodule

// File: tb/tb_test_harness_ctrl.sv
// Bench for test_harness_ctrl: directed run scenarios plus random store traffic,
// two instances (watchdog 25 and watchdog disabled) against a run-level model.
module tb_test_harness_ctrl;

    localparam int          RST_CYCLES = 3;
    localparam int          TMO_A      = 25;
    localparam logic [31:0] TOHOST     = 32'h0000_1000;
    localparam logic [31:0] CONSOLE    = 32'h0000_1004;

    localparam int P_HOLD = 0, P_RUN = 1, P_DONE = 2;
    localparam int R_NONE = 0, R_PASS = 1, R_FAIL = 2, R_TIMEOUT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        we = 1'b0;
    logic        nowd_we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    bit          nowd_follow = 1'b0;

    logic        a_core_rst_n, a_running, a_done, a_pass, a_fail, a_timeout, a_char_valid;
    logic [30:0] a_fail_code;
    logic [31:0] a_cycle_cnt;
    logic [7:0]  a_char_data;
    logic        b_core_rst_n, b_running, b_done, b_pass, b_fail, b_timeout, b_char_valid;
    logic [30:0] b_fail_code;
    logic [31:0] b_cycle_cnt;
    logic [7:0]  b_char_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    test_harness_ctrl #(.RST_CYCLES(RST_CYCLES), .TIMEOUT_CYCLES(TMO_A)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .dmem_we(we), .dmem_addr(addr), .dmem_wdata(wdata),
        .core_rst_n(a_core_rst_n), .running(a_running), .done(a_done),
        .pass(a_pass), .fail(a_fail), .timeout(a_timeout),
        .fail_code(a_fail_code), .cycle_cnt(a_cycle_cnt),
        .char_valid(a_char_valid), .char_data(a_char_data)
    );

    test_harness_ctrl #(.RST_CYCLES(RST_CYCLES), .TIMEOUT_CYCLES(0)) dut_nowd (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .dmem_we(nowd_we), .dmem_addr(addr), .dmem_wdata(wdata),
        .core_rst_n(b_core_rst_n), .running(b_running), .done(b_done),
        .pass(b_pass), .fail(b_fail), .timeout(b_timeout),
        .fail_code(b_fail_code), .cycle_cnt(b_cycle_cnt),
        .char_valid(b_char_valid), .char_data(b_char_data)
    );

    // Run-level model: phase, cycles spent in RUN, verdict and last console byte.
    typedef struct {
        int          phase;
        int          hold;
        longint      cnt;
        int          result;
        logic [30:0] fc;
        bit          cv;
        logic [7:0]  cd;
    } model_t;

    model_t ma, mb;

    function automatic model_t model_reset();
        model_t m;
        m.phase = P_HOLD; m.hold = 0; m.cnt = 0; m.result = R_NONE;
        m.fc = '0; m.cv = 1'b0; m.cd = '0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, int tmo, bit rn, bit rs,
                                          bit w, logic [31:0] a, logic [31:0] d);
        bit decisive;
        if (!rn) return model_reset();
        m.cv = 1'b0;
        case (m.phase)
            P_HOLD: begin
                m.hold++;
                if (m.hold == RST_CYCLES) m.phase = P_RUN;
            end
            P_RUN: begin
                m.cnt++;
                if (w && a == CONSOLE) begin
                    m.cv = 1'b1;
                    m.cd = d[7:0];
                end
                decisive = w && (a == TOHOST) && d[0];
                if (decisive) begin
                    m.phase = P_DONE;
                    if (d == 32'd1) m.result = R_PASS;
                    else begin
                        m.result = R_FAIL;
                        m.fc = d[31:1];
                    end
                end else if (tmo != 0 && m.cnt == tmo) begin
                    m.phase = P_DONE;
                    m.result = R_TIMEOUT;
                end
            end
            default: begin
                if (rs) begin
                    m.phase = P_HOLD; m.hold = 0; m.cnt = 0;
                    m.result = R_NONE; m.fc = '0;
                end
            end
        endcase
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string n, input model_t m,
                            input logic cr, input logic run, input logic dn,
                            input logic ps, input logic fl, input logic to,
                            input logic [30:0] fc, input logic [31:0] cc,
                            input logic cv, input logic [7:0] cd);
        bit is_d;
        is_d = (m.phase == P_DONE);
        check({n, ".core_rst_n"}, cr, m.phase == P_RUN);
        check({n, ".running"},    run, m.phase == P_RUN);
        check({n, ".done"},       dn, is_d);
        check({n, ".pass"},       ps, is_d && m.result == R_PASS);
        check({n, ".fail"},       fl, is_d && m.result == R_FAIL);
        check({n, ".timeout"},    to, is_d && m.result == R_TIMEOUT);
        check({n, ".fail_code"},  fc, m.fc);
        check({n, ".cycle_cnt"},  cc, m.cnt);
        check({n, ".char_valid"}, cv, m.cv);
        check({n, ".char_data"},  cd, m.cd);
    endtask

    task automatic tick();
        @(posedge clk);
        ma = model_step(ma, TMO_A, rst_n, restart, we, addr, wdata);
        mb = model_step(mb, 0, rst_n, restart, nowd_we, addr, wdata);
        @(negedge clk);
        cmp_inst("a", ma, a_core_rst_n, a_running, a_done, a_pass, a_fail, a_timeout,
                 a_fail_code, a_cycle_cnt, a_char_valid, a_char_data);
        cmp_inst("b", mb, b_core_rst_n, b_running, b_done, b_pass, b_fail, b_timeout,
                 b_fail_code, b_cycle_cnt, b_char_valid, b_char_data);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; nowd_we = nowd_follow; addr = a; wdata = d;
        tick();
        we = 1'b0; nowd_we = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic random_run(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            restart = ($urandom_range(0, 15) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
            r = $urandom_range(0, 99);
            we = 1'b0; addr = $urandom; wdata = $urandom;
            if (r < 4) begin
                we = 1'b1; addr = TOHOST;
                case ($urandom_range(0, 4))
                    0: wdata = 32'd0;
                    1: wdata = 32'd1;
                    2: wdata = 32'd2;
                    3: wdata = 32'd7;
                    default: wdata = $urandom;
                endcase
            end else if (r < 14) begin
                we = 1'b1; addr = CONSOLE;
            end else if (r < 30) begin
                we = 1'b1; addr = 32'h0000_1000 + 32'($urandom_range(0, 15));
            end
            nowd_we = we;
            tick();
        end
        we = 1'b0; nowd_we = 1'b0; restart = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        ma = model_reset();
        mb = model_reset();

        // Reset for two cycles, then the stretched core reset.
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("hold.core_rst_n", a_core_rst_n, 1'b0);
        tick();
        check("release.core_rst_n", a_core_rst_n, 1'b1);
        check("release.running", a_running, 1'b1);
        check("release.cycle_cnt", a_cycle_cnt, 32'd0);

        // Pass store at cycle 10.
        repeat (10) tick();
        check("pre_pass.cycle_cnt", a_cycle_cnt, 32'd10);
        store(TOHOST, 32'd1);
        check("pass.pass", a_pass, 1'b1);
        check("pass.timeout", a_timeout, 1'b0);
        check("pass.core_rst_n", a_core_rst_n, 1'b0);
        check("pass.cycle_cnt", a_cycle_cnt, 32'd11);

        // Fail with code 3; a later pass store is ignored.
        pulse_restart();
        check("restart.done", a_done, 1'b0);
        repeat (RST_CYCLES) tick();
        store(TOHOST, 32'h0000_0007);
        check("fail.fail", a_fail, 1'b1);
        check("fail.fail_code", a_fail_code, 31'd3);
        store(TOHOST, 32'd1);
        check("fail_then_pass.pass", a_pass, 1'b0);

        // Watchdog expiry after 25 RUN cycles.
        pulse_restart();
        repeat (RST_CYCLES) tick();
        repeat (TMO_A - 1) tick();
        check("pre_timeout.running", a_running, 1'b1);
        tick();
        check("timeout.timeout", a_timeout, 1'b1);
        check("timeout.cycle_cnt", a_cycle_cnt, 32'd25);

        // Pass store on the expiry cycle wins.
        pulse_restart();
        repeat (RST_CYCLES) tick();
        repeat (TMO_A - 1) tick();
        store(TOHOST, 32'd1);
        check("tie.pass", a_pass, 1'b1);
        check("tie.timeout", a_timeout, 1'b0);

        // Console bytes back to back, then an even tohost value.
        pulse_restart();
        repeat (RST_CYCLES) tick();
        store(CONSOLE, 32'h0000_0048);
        check("char0.valid", a_char_valid, 1'b1);
        check("char0.data", a_char_data, 8'h48);
        store(CONSOLE, 32'h0000_0069);
        check("char1.valid", a_char_valid, 1'b1);
        check("char1.data", a_char_data, 8'h69);
        store(TOHOST, 32'd2);
        check("even.running", a_running, 1'b1);
        check("even.char_valid", a_char_valid, 1'b0);

        // Disabled watchdog never expires.
        repeat (1000) tick();
        check("nowd.running", b_running, 1'b1);
        check("nowd.timeout", b_timeout, 1'b0);

        nowd_follow = 1'b1;
        random_run(1500);

        // Asynchronous reset in the middle of a run.
        for (int k = 0; k < 200 && ma.phase != P_RUN; k++) begin
            restart = 1'b1;
            tick();
        end
        restart = 1'b0;
        repeat (5) tick();
        check("pre_async.running", a_running, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async.core_rst_n", a_core_rst_n, 1'b0);
        check("async.running", a_running, 1'b0);
        check("async.cycle_cnt", a_cycle_cnt, 32'd0);
        check("async.flags", {a_done, a_pass, a_fail, a_timeout, a_char_valid}, 5'd0);
        check("async.fail_code", a_fail_code, 31'd0);
        check("async.char_data", a_char_data, 8'd0);
        check("async.b_running", b_running, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (RST_CYCLES) tick();
        check("rerun.running", a_running, 1'b1);

        random_run(800);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/test_harness_ctrl.md
Name: test_harness_ctrl

Overview:
Synthesizable run controller for CPU bring-up. It sits between the board/bench reset and CPU_CORE_TOP, and snoops the core's data-memory store bus. It provides:
- a stretched core reset
- a cycle watchdog
- tohost pass/fail detection
- a byte console port

It replaces fixed-time `$finish` benches with a parametrised, restartable, self-checking run sequence.

Parameters:
RST_CYCLES, 3, number of clk cycles core_rst_n is held low after rst_n deasserts (≥1)
TIMEOUT_CYCLES, 25, cycle limit in RUN; 0 disables the watchdog
ADDR_W, 32, dmem address width
DATA_W, 32, dmem data width (≥8)
CNT_W, 32, cycle counter width
TOHOST_ADDR, 32'h0000_1000, store address that ends the test
CONSOLE_ADDR, 32'h0000_1004, store address whose low byte is emitted as a console character

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
restart  in  1  one-cycle request to rerun; honoured only in a DONE state
dmem_we  in  1  core store strobe (snooped)
dmem_addr  in  ADDR_W  core data address (snooped)
dmem_wdata  in  DATA_W  core store data (snooped)
core_rst_n  out  1  registered active-low reset to CPU core
running  out  1  high in RUN
done  out  1  high in any DONE state
pass  out  1  tohost value == 1
fail  out  1  tohost value odd and != 1
timeout  out  1  watchdog expired
fail_code  out  DATA_W-1  tohost value >> 1, valid when fail
cycle_cnt  out  CNT_W  cycles spent in RUN, frozen in DONE
char_valid  out  1  one-cycle pulse per console store
char_data  out  8  console byte

Behaviour:
- Reset state (rst_n low, asynchronous):
  - state=HOLD, hold counter=0, core_rst_n=0
  - running, done, pass, fail, timeout, char_valid = 0
  - fail_code=0, cycle_cnt=0, char_data=0
- States: HOLD, RUN, DONE_PASS, DONE_FAIL, DONE_TIMEOUT. The three DONE states are collectively "DONE"; done=1 in any of them.
- HOLD:
  - hold counter increments each clk.
  - When the counter reaches RST_CYCLES-1, go to RUN next edge.
  - core_rst_n is registered: it rises exactly RST_CYCLES clk edges after rst_n rises.
- RUN:
  - running=1; cycle_cnt increments every cycle, saturating at all-ones.
  - A store is a cycle with dmem_we=1; it is sampled at posedge. Only stores in RUN are acted on.
  - Store to TOHOST_ADDR with wdata==1 → DONE_PASS.
  - Store to TOHOST_ADDR with odd wdata != 1 → DONE_FAIL, fail_code = wdata>>1.
  - Store to TOHOST_ADDR with even wdata (including 0) → ignored, stay in RUN.
  - Store to CONSOLE_ADDR → next cycle char_valid=1 for exactly one cycle, char_data=wdata[7:0]. Back-to-back stores give back-to-back pulses.
  - Watchdog: if TIMEOUT_CYCLES != 0 and cycle_cnt == TIMEOUT_CYCLES-1 at a posedge with no decisive tohost store → DONE_TIMEOUT.
  - Simultaneous events: a decisive tohost store beats the watchdog in the same cycle.
- DONE:
  - Exactly one of pass/fail/timeout is 1; all three are sticky.
  - core_rst_n=0 from the first DONE cycle, freezing the core.
  - cycle_cnt is frozen; dmem stores are ignored; no char_valid pulses.
- restart:
  - In DONE, restart=1 → HOLD next edge. Result flags, fail_code, cycle_cnt and hold counter clear on entry to HOLD.
  - In HOLD or RUN, restart is ignored.
- rst_n low at any time, including mid-RUN or mid-HOLD: immediate return to reset state; no result survives.
- Address compare is full ADDR_W equality. No byte-lane or width decoding is done on the store.

Decomposition:
- Shared package harness_pkg holds:
  - state enum/localparams (HOLD, RUN, DONE_PASS, DONE_FAIL, DONE_TIMEOUT)
  - default TOHOST_ADDR and CONSOLE_ADDR
  - the PASS value constant (1)
- One natural sub-module: harness_store_decode. It is combinational address match plus tohost classification (pass / fail / ignore), reused by later multi-core harnesses.
- Counters and FSM stay in the top.

Test Plan:
- rst_n low 2 cycles then high, RST_CYCLES=3 → core_rst_n rises on the 3rd posedge after release; running=1 on the same cycle; cycle_cnt counts from 0.
- In RUN, store 32'h1 to 32'h1000 at cycle 10 → next cycle done=1, pass=1, fail=0, timeout=0, core_rst_n=0, cycle_cnt frozen at 11.
- Store 32'h0000_0007 to 32'h1000 → fail=1, fail_code=3. A following store of 32'h1 is ignored; pass stays 0.
- No tohost store, TIMEOUT_CYCLES=25 → timeout=1 after 25 RUN cycles. Variants:
  - a pass store on the expiry cycle yields pass=1, timeout=0;
  - TIMEOUT_CYCLES=0 never times out over 1000 cycles.
- Stores of 8'h48, 8'h69 to 32'h1004 on consecutive cycles → two consecutive char_valid pulses, char_data 8'h48 then 8'h69. A store of 32'h2 to 32'h1000 is ignored, stays RUN.
- In DONE_FAIL, pulse restart → HOLD, flags clear, rerun reaches pass. Assert rst_n low mid-RUN → all outputs reset asynchronously, before the next clk edge.
